// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizing for the reorder buffer and its consumers.
package reorder_buffer_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SIZE   = 8;
  localparam int unsigned NUM_WB = 3;
  localparam int unsigned TAG_W  = $clog2(SIZE);
  localparam int unsigned XLEN   = 32;

  typedef logic [TAG_W-1:0] rob_tag_t;

  // Decoded instruction info carried alongside each ROB entry.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] branch_pc;
  } pci_t;

  // Per-entry retire view consumed by the regfile and the commit checker.
  typedef struct packed {
    logic             rdy;
    logic [WIDTH-1:0] data;
    pci_t             pc_info;
  } sal2_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t front_tag;
    rob_tag_t rear_tag;
  } flush_t;

endpackage

// File: rtl/rob_commit_select.sv
// Picks the in-order run of completed entries that retire this cycle,
// stopping after the first mispredicted one.
module rob_commit_select #(
  parameter int unsigned size = 8
) (
  input  logic [$clog2(size)-1:0] front,
  input  logic [size-1:0]         valid,
  input  logic [size-1:0]         done,
  input  logic [size-1:0]         mispredict,
  output logic [size-1:0]         retire,
  output logic [$clog2(size):0]   n,
  output logic                    flush_valid,
  output logic [$clog2(size)-1:0] flush_idx
);

  localparam int unsigned TAG_W = $clog2(size);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic             stop;
  logic [TAG_W-1:0] idx;

  // Walk from front; the first non-completed or mispredicted entry ends the run.
  always_comb begin
    retire      = '0;
    n           = '0;
    flush_valid = 1'b0;
    flush_idx   = '0;
    stop        = 1'b0;
    idx         = '0;
    for (int k = 0; k < int'(size); k++) begin
      idx = front + TAG_W'(k);
      if (!stop) begin
        if (valid[idx] && done[idx]) begin
          retire[idx] = 1'b1;
          n           = n + CNT_W'(1);
          if (mispredict[idx]) begin
            flush_valid = 1'b1;
            flush_idx   = idx;
            stop        = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at dispatch, capture writeback
// results, retire completed runs in order and flush on a mispredicted retire.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned width  = WIDTH,
  parameter int unsigned size   = SIZE,
  parameter int unsigned num_wb = NUM_WB
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  input  pci_t                    enq_pci,
  output logic                    enq_ready,
  output logic [$clog2(size)-1:0] enq_tag,
  input  logic [num_wb-1:0]       wb_valid,
  input  logic [$clog2(size)-1:0] wb_tag        [num_wb],
  input  logic [width-1:0]        wb_data       [num_wb],
  input  logic [num_wb-1:0]       wb_mispredict,
  input  logic [31:0]             wb_target     [num_wb],
  output sal2_t                   rdest         [size],
  output logic [4:0]              rd_bus        [size],
  output logic                    commit,
  output flush_t                  flush,
  output logic                    pc_load,
  output logic [31:0]             pc_target
);

  localparam int unsigned TAG_W_L = $clog2(size);
  localparam int unsigned CNT_W   = TAG_W_L + 1;

  logic [size-1:0]    valid_q, valid_d;
  logic [size-1:0]    done_q, done_d;
  logic [size-1:0]    mis_q, mis_d;
  logic [31:0]        target_q [size];
  logic [31:0]        target_d [size];
  logic [width-1:0]   data_q   [size];
  logic [width-1:0]   data_d   [size];
  pci_t               pci_q    [size];
  pci_t               pci_d    [size];
  logic [TAG_W_L-1:0] front_q, front_d;
  logic [TAG_W_L-1:0] rear_q, rear_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [size-1:0]    retire;
  logic [CNT_W-1:0]   retire_n;
  logic               flush_c;
  logic [TAG_W_L-1:0] flush_idx;
  logic               do_enq;

  rob_commit_select #(
    .size (size)
  ) u_commit_select (
    .front       (front_q),
    .valid       (valid_q),
    .done        (done_q),
    .mispredict  (mis_q),
    .retire      (retire),
    .n           (retire_n),
    .flush_valid (flush_c),
    .flush_idx   (flush_idx)
  );

  // Allocation handshake: registered count only, blocked during a flush.
  always_comb begin
    enq_ready = (count_q < CNT_W'(size)) && !flush_c;
    enq_tag   = rear_q;
    do_enq    = enq_valid && enq_ready;
  end

  // Next-state: flush wipes everything, else writeback, retire, then allocate.
  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    mis_d    = mis_q;
    target_d = target_q;
    data_d   = data_q;
    pci_d    = pci_q;
    front_d  = front_q;
    rear_d   = rear_q;
    count_d  = count_q;
    if (flush_c) begin
      valid_d = '0;
      done_d  = '0;
      mis_d   = '0;
      front_d = rear_q;
      count_d = '0;
    end else begin
      // Highest bus first so the lowest index lands last and wins on a tie.
      for (int b = int'(num_wb) - 1; b >= 0; b--) begin
        if (wb_valid[b] && valid_q[wb_tag[b]]) begin
          done_d[wb_tag[b]]   = 1'b1;
          data_d[wb_tag[b]]   = wb_data[b];
          mis_d[wb_tag[b]]    = wb_mispredict[b];
          target_d[wb_tag[b]] = wb_target[b];
        end
      end
      for (int j = 0; j < int'(size); j++) begin
        if (retire[j]) begin
          valid_d[j] = 1'b0;
          done_d[j]  = 1'b0;
          mis_d[j]   = 1'b0;
        end
      end
      if (do_enq) begin
        valid_d[rear_q] = 1'b1;
        done_d[rear_q]  = 1'b0;
        mis_d[rear_q]   = 1'b0;
        pci_d[rear_q]   = enq_pci;
        rear_d          = rear_q + TAG_W_L'(1);
      end
      front_d = front_q + TAG_W_L'(retire_n);
      count_d = count_q + CNT_W'(do_enq) - retire_n;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      mis_q   <= '0;
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(size); i++) begin
        target_q[i] <= '0;
        data_q[i]   <= '0;
        pci_q[i]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      front_q  <= front_d;
      rear_q   <= rear_d;
      count_q  <= count_d;
      target_q <= target_d;
      data_q   <= data_d;
      pci_q    <= pci_d;
    end
  end

  // Retire view and redirect, all derived from registered state.
  always_comb begin
    for (int j = 0; j < int'(size); j++) begin
      rdest[j].rdy     = retire[j];
      rdest[j].data    = valid_q[j] ? WIDTH'(data_q[j]) : '0;
      rdest[j].pc_info = valid_q[j] ? pci_q[j] : '0;
      rd_bus[j]        = valid_q[j] ? pci_q[j].rd : 5'd0;
    end
    commit          = |retire;
    flush.valid     = flush_c;
    flush.front_tag = TAG_W'(front_q);
    flush.rear_tag  = TAG_W'(rear_q);
    pc_load         = flush_c;
    pc_target       = flush_c ? target_q[flush_idx] : 32'd0;
  end

endmodule
